// File: rtl/Noc_parameters.sv
// Shared NoC parameters: default VC count, flit width and credit counter sizing.
package Noc_parameters;

   localparam int Noc_VC_Channel = 4;
   localparam int Noc_Flit_Width = 32;
   localparam int Noc_Credits    = 4;
   localparam int CREDIT_W       = $clog2(Noc_Credits + 1);

   function automatic int credit_width(input int credits);
      return $clog2(credits + 1);
   endfunction

endpackage

// File: rtl/Noc_fifo.sv
// Single-clock FIFO with optional registered empty/full flags; data is read from the head slot.
module Noc_fifo #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 8,
   parameter int FLAG_FF_OUT = 1
) (
   input  logic             noc_clk,
   input  logic             noc_rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + (AW+1)'(1);
         2'b01:   count_nxt = count - (AW+1)'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
      end
   end

   always_ff @(posedge noc_clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

   // Registered flags follow next-cycle occupancy, so a push is never visible in its own cycle.
   generate
      if (FLAG_FF_OUT != 0) begin : g_flag_ff
         always_ff @(posedge noc_clk or negedge noc_rst_n) begin
            if (!noc_rst_n) begin
               empty <= 1'b1;
               full  <= 1'b0;
            end else if (clear) begin
               empty <= 1'b1;
               full  <= 1'b0;
            end else begin
               empty <= (count_nxt == '0);
               full  <= (count_nxt == (AW+1)'(DEPTH));
            end
         end
      end else begin : g_flag_comb
         assign empty = (count == '0);
         assign full  = (count == (AW+1)'(DEPTH));
      end
   endgenerate

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter; pointer advances past the winner on transfer, grant held while locked.
module noc_rr_arbiter #(
   parameter int N = 2
) (
   input  logic         noc_clk,
   input  logic         noc_rst_n,
   input  logic         clear,
   input  logic [N-1:0] req,
   input  logic         lock,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr;
   logic [IW-1:0] gidx;
   logic [IW:0]   sum;
   logic [N-1:0]  rr_grant;
   logic [N-1:0]  held;
   logic          locked;
   logic          found;

   always_comb begin
      rr_grant = '0;
      found    = 1'b0;
      sum      = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
         if (!found && req[sum[IW-1:0]]) begin
            rr_grant[sum[IW-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end

   // A stalled output keeps last cycle's winner even if a higher-priority VC becomes eligible.
   assign grant = locked ? (held & req) : rr_grant;

   always_comb begin
      gidx = '0;
      for (int k = 0; k < N; k++) begin
         if (grant[k]) gidx = IW'(k);
      end
   end

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         ptr    <= '0;
         held   <= '0;
         locked <= 1'b0;
      end else if (clear) begin
         ptr    <= '0;
         held   <= '0;
         locked <= 1'b0;
      end else begin
         locked <= lock;
         held   <= grant;
         if (advance) ptr <= (gidx == IW'(N-1)) ? '0 : gidx + IW'(1);
      end
   end

endmodule

// File: rtl/noc_vc_credit_buffer.sv
// Per-VC input queues with downstream credit tracking and round-robin output selection.
module noc_vc_credit_buffer
   import Noc_parameters::*;
#(
   parameter int CHANNELS   = Noc_VC_Channel,
   parameter int DEPTH      = 8,
   parameter int FLIT_WIDTH = Noc_Flit_Width,
   parameter int CREDITS    = 4
) (
   input  logic                  noc_clk,
   input  logic                  noc_rst_n,
   input  logic                  i_clear,
   input  logic [CHANNELS-1:0]   i_valid,
   input  logic [FLIT_WIDTH-1:0] i_flit,
   output logic [CHANNELS-1:0]   o_ready,
   output logic [CHANNELS-1:0]   o_credit_return,
   output logic                  o_valid,
   output logic [CHANNELS-1:0]   o_vc,
   output logic [FLIT_WIDTH-1:0] o_flit,
   input  logic                  i_ready,
   input  logic [CHANNELS-1:0]   i_credit,
   output logic [CHANNELS-1:0]   o_empty,
   output logic [CHANNELS-1:0]   o_full,
   output logic [1:0]            o_error
);

   localparam int CW = credit_width(CREDITS);

   logic [CHANNELS-1:0]   fifo_empty;
   logic [CHANNELS-1:0]   fifo_full;
   logic [FLIT_WIDTH-1:0] fifo_dout [CHANNELS];
   logic [CHANNELS-1:0]   push;
   logic [CHANNELS-1:0]   pop;
   logic [CHANNELS-1:0]   eligible;
   logic [CHANNELS-1:0]   grant;
   logic [CHANNELS-1:0]   cred_ovf;
   logic [CW-1:0]         credit [CHANNELS];
   logic                  multi_hot;
   logic                  transfer;

   assign multi_hot = |(i_valid & (i_valid - CHANNELS'(1)));
   assign push      = multi_hot ? '0 : (i_valid & ~fifo_full);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_vc
      Noc_fifo #(
         .WIDTH       (FLIT_WIDTH),
         .DEPTH       (DEPTH),
         .FLAG_FF_OUT (1)
      ) u_fifo (
         .noc_clk   (noc_clk),
         .noc_rst_n (noc_rst_n),
         .clear     (i_clear),
         .push      (push[g]),
         .din       (i_flit),
         .pop       (pop[g]),
         .dout      (fifo_dout[g]),
         .empty     (fifo_empty[g]),
         .full      (fifo_full[g])
      );

      assign eligible[g] = !fifo_empty[g] && (credit[g] != '0);
      assign cred_ovf[g] = i_credit[g] && !pop[g] && (credit[g] == CW'(CREDITS));
   end

   noc_rr_arbiter #(
      .N (CHANNELS)
   ) u_arb (
      .noc_clk   (noc_clk),
      .noc_rst_n (noc_rst_n),
      .clear     (i_clear),
      .req       (eligible),
      .lock      (o_valid && !i_ready),
      .advance   (transfer),
      .grant     (grant)
   );

   assign o_valid  = |grant;
   assign o_vc     = grant;
   assign transfer = o_valid && i_ready;
   assign pop      = transfer ? grant : '0;

   always_comb begin
      o_flit = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (grant[k]) o_flit = o_flit | fifo_dout[k];
      end
   end

   // A send and a returning credit in the same cycle cancel out.
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         for (int k = 0; k < CHANNELS; k++) credit[k] <= CW'(CREDITS);
      end else if (i_clear) begin
         for (int k = 0; k < CHANNELS; k++) credit[k] <= CW'(CREDITS);
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            case ({pop[k], i_credit[k]})
               2'b10:   credit[k] <= credit[k] - CW'(1);
               2'b01:   if (!cred_ovf[k]) credit[k] <= credit[k] + CW'(1);
               default: credit[k] <= credit[k];
            endcase
         end
      end
   end

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         o_credit_return <= '0;
         o_error         <= '0;
      end else if (i_clear) begin
         o_credit_return <= '0;
         o_error         <= '0;
      end else begin
         o_credit_return <= pop;
         o_error[0]      <= o_error[0] | multi_hot;
         o_error[1]      <= o_error[1] | (|cred_ovf);
      end
   end

   assign o_ready = ~fifo_full;
   assign o_empty = fifo_empty;
   assign o_full  = fifo_full;

endmodule

// File: tb/tb_noc_vc_credit_buffer.sv
// Scoreboard bench for noc_vc_credit_buffer with two VCs, four-deep queues and two credits.
module tb_noc_vc_credit_buffer;
   import Noc_parameters::*;

   localparam int CH = 2;
   localparam int DP = 4;
   localparam int CR = 2;
   localparam int FW = Noc_Flit_Width;

   logic          noc_clk   = 1'b0;
   logic          noc_rst_n = 1'b0;
   logic          i_clear   = 1'b0;
   logic [CH-1:0] i_valid   = '0;
   logic [FW-1:0] i_flit    = '0;
   logic          i_ready   = 1'b0;
   logic [CH-1:0] i_credit  = '0;
   logic [CH-1:0] o_ready;
   logic [CH-1:0] o_credit_return;
   logic          o_valid;
   logic [CH-1:0] o_vc;
   logic [FW-1:0] o_flit;
   logic [CH-1:0] o_empty;
   logic [CH-1:0] o_full;
   logic [1:0]    o_error;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [FW-1:0] sb0 [$];
   logic [FW-1:0] sb1 [$];
   logic [CH-1:0] exp_cr   = '0;
   logic          loopback = 1'b0;
   int            mon_s0;
   int            mon_s1;

   noc_vc_credit_buffer #(
      .CHANNELS   (CH),
      .DEPTH      (DP),
      .FLIT_WIDTH (FW),
      .CREDITS    (CR)
   ) dut (
      .noc_clk         (noc_clk),
      .noc_rst_n       (noc_rst_n),
      .i_clear         (i_clear),
      .i_valid         (i_valid),
      .i_flit          (i_flit),
      .o_ready         (o_ready),
      .o_credit_return (o_credit_return),
      .o_valid         (o_valid),
      .o_vc            (o_vc),
      .o_flit          (o_flit),
      .i_ready         (i_ready),
      .i_credit        (i_credit),
      .o_empty         (o_empty),
      .o_full          (o_full),
      .o_error         (o_error)
   );

   always #5 noc_clk = ~noc_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [CH-1:0] v, input logic [FW-1:0] f, input logic r,
                       input logic [CH-1:0] c);
      @(posedge noc_clk);
      #1;
      i_valid  = v;
      i_flit   = f;
      i_ready  = r;
      i_credit = loopback ? o_credit_return : c;
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n        = 0;
      loopback = 1'b1;
      while ((sb0.size() != 0 || sb1.size() != 0) && n < max_cycles) begin
         step('0, '0, 1'b1, '0);
         n++;
      end
      repeat (3) step('0, '0, 1'b1, '0);
      loopback = 1'b0;
      step('0, '0, 1'b1, '0);
      chk("drain_left", 64'(sb0.size() + sb1.size()), 64'(0));
      chk("drain_empty", 64'(o_empty), 64'(2'b11));
   endtask

   // Scoreboard: transfers are compared against queued pushes, then this cycle's push is modelled.
   always @(negedge noc_clk) begin
      if (!noc_rst_n) begin
         sb0.delete();
         sb1.delete();
         exp_cr = '0;
      end else begin
         chk("credit_return", 64'(o_credit_return), 64'(exp_cr));
         if (!o_valid) chk("vc_idle", 64'(o_vc), 64'(0));
         if (i_clear) begin
            sb0.delete();
            sb1.delete();
            exp_cr = '0;
         end else begin
            mon_s0 = sb0.size();
            mon_s1 = sb1.size();
            exp_cr = '0;
            if (o_valid && i_ready) begin
               exp_cr = o_vc;
               if (o_vc == 2'b01) begin
                  chk("xfer_vc0_nonempty", 64'(sb0.size() != 0), 64'(1));
                  if (sb0.size() != 0) chk("xfer_vc0_flit", 64'(o_flit), 64'(sb0.pop_front()));
               end else if (o_vc == 2'b10) begin
                  chk("xfer_vc1_nonempty", 64'(sb1.size() != 0), 64'(1));
                  if (sb1.size() != 0) chk("xfer_vc1_flit", 64'(o_flit), 64'(sb1.pop_front()));
               end else begin
                  chk("xfer_vc_onehot", 64'($onehot(o_vc)), 64'(1));
               end
            end
            if (i_valid == 2'b01 && mon_s0 < DP) sb0.push_back(i_flit);
            if (i_valid == 2'b10 && mon_s1 < DP) sb1.push_back(i_flit);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge noc_clk);
      @(negedge noc_clk);
      chk("rst_empty", 64'(o_empty), 64'(2'b11));
      chk("rst_full", 64'(o_full), 64'(0));
      chk("rst_ready", 64'(o_ready), 64'(2'b11));
      chk("rst_valid", 64'(o_valid), 64'(0));
      chk("rst_error", 64'(o_error), 64'(0));
      @(posedge noc_clk);
      #1 noc_rst_n = 1'b1;

      // VC0 with no returning credit: two flits go, the third waits for a credit
      step(2'b01, 32'hA000, 1'b1, 2'b00);
      @(negedge noc_clk) chk("s1_no_fallthru", 64'(o_valid), 64'(0));
      step(2'b01, 32'hA001, 1'b1, 2'b00);
      @(negedge noc_clk) chk("s1_a0", 64'(o_flit), 64'(32'hA000));
      step(2'b01, 32'hA002, 1'b1, 2'b00);
      @(negedge noc_clk) chk("s1_a1", 64'(o_flit), 64'(32'hA001));
      step('0, '0, 1'b1, 2'b00);
      @(negedge noc_clk) chk("s1_stall0", 64'(o_valid), 64'(0));
      step('0, '0, 1'b1, 2'b00);
      @(negedge noc_clk) chk("s1_stall1", 64'(o_valid), 64'(0));
      step('0, '0, 1'b1, 2'b01);
      @(negedge noc_clk) chk("s1_stall_credit", 64'(o_valid), 64'(0));
      step('0, '0, 1'b1, 2'b00);
      @(negedge noc_clk) chk("s1_a2", 64'(o_flit), 64'(32'hA002));
      step('0, '0, 1'b1, 2'b00);
      @(negedge noc_clk) chk("s1_empty", 64'(o_empty), 64'(2'b11));
      step('0, '0, 1'b1, 2'b01);
      step('0, '0, 1'b1, 2'b01);
      step('0, '0, 1'b1, 2'b00);
      @(negedge noc_clk) chk("s1_no_error", 64'(o_error), 64'(0));

      // VC1 filled to depth, fifth push must be dropped
      for (int k = 0; k < 4; k++) step(2'b10, 32'hB000 + 32'(k), 1'b0, 2'b00);
      step(2'b10, 32'hB004, 1'b0, 2'b00);
      @(negedge noc_clk);
      chk("s2_full", 64'(o_full), 64'(2'b10));
      chk("s2_ready", 64'(o_ready), 64'(2'b01));
      step('0, '0, 1'b0, 2'b00);
      @(negedge noc_clk) chk("s2_full_hold", 64'(o_full), 64'(2'b10));
      drain(40);

      // Both VCs loaded: grants alternate
      step(2'b01, 32'hC000, 1'b0, 2'b00);
      step(2'b10, 32'hD000, 1'b0, 2'b00);
      step(2'b01, 32'hC001, 1'b0, 2'b00);
      step(2'b10, 32'hD001, 1'b0, 2'b00);
      loopback = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step('0, '0, 1'b1, 2'b00);
         @(negedge noc_clk) chk("s3_rr_vc", 64'(o_vc), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      end
      drain(20);

      // Stall with a competing VC arriving: grant stays locked on VC1
      step(2'b10, 32'hE000, 1'b0, 2'b00);
      @(negedge noc_clk) chk("s4_not_yet", 64'(o_valid), 64'(0));
      step(2'b01, 32'hF000, 1'b0, 2'b00);
      @(negedge noc_clk) chk("s4_hold_vc0", 64'(o_vc), 64'(2'b10));
      for (int k = 0; k < 2; k++) begin
         step('0, '0, 1'b0, 2'b00);
         @(negedge noc_clk);
         chk("s4_hold_vc", 64'(o_vc), 64'(2'b10));
         chk("s4_hold_flit", 64'(o_flit), 64'(32'hE000));
      end
      loopback = 1'b1;
      step('0, '0, 1'b1, 2'b00);
      @(negedge noc_clk) chk("s4_release_flit", 64'(o_flit), 64'(32'hE000));
      step('0, '0, 1'b1, 2'b00);
      @(negedge noc_clk);
      chk("s4_cr_pulse", 64'(o_credit_return), 64'(2'b10));
      chk("s4_next_flit", 64'(o_flit), 64'(32'hF000));
      drain(10);

      // Credit overflow and multi-hot push
      step('0, '0, 1'b1, 2'b01);
      step(2'b11, 32'h5555, 1'b1, 2'b00);
      @(negedge noc_clk) chk("s5_ovf_err", 64'(o_error), 64'(2'b10));
      step('0, '0, 1'b1, 2'b00);
      @(negedge noc_clk);
      chk("s5_multi_err", 64'(o_error), 64'(2'b11));
      chk("s5_multi_nopush", 64'(o_empty), 64'(2'b11));
      step(2'b01, 32'h6000, 1'b1, 2'b00);
      step(2'b01, 32'h6001, 1'b1, 2'b00);
      step(2'b01, 32'h6002, 1'b1, 2'b00);
      step('0, '0, 1'b1, 2'b00);
      step('0, '0, 1'b1, 2'b00);
      @(negedge noc_clk);
      chk("s5_credit_sat", 64'(o_valid), 64'(0));
      chk("s5_credit_left", 64'(o_empty), 64'(2'b10));

      // Asynchronous reset with flits queued and an output about to transfer
      step(2'b01, 32'h6003, 1'b0, 2'b00);
      step(2'b10, 32'h7000, 1'b0, 2'b00);
      step('0, '0, 1'b0, 2'b00);
      @(negedge noc_clk) chk("s6_pre_valid", 64'(o_valid), 64'(1));
      @(posedge noc_clk);
      #1 i_ready = 1'b1;
      #2 noc_rst_n = 1'b0;
      #1;
      chk("s6_rst_empty", 64'(o_empty), 64'(2'b11));
      chk("s6_rst_valid", 64'(o_valid), 64'(0));
      chk("s6_rst_error", 64'(o_error), 64'(0));
      @(posedge noc_clk);
      #1 noc_rst_n = 1'b1;
      step(2'b01, 32'h8000, 1'b1, 2'b00);
      step(2'b01, 32'h8001, 1'b1, 2'b00);
      step(2'b01, 32'h8002, 1'b1, 2'b00);
      step('0, '0, 1'b1, 2'b00);
      step('0, '0, 1'b1, 2'b00);
      @(negedge noc_clk);
      chk("s6_post_valid", 64'(o_valid), 64'(0));
      chk("s6_post_empty", 64'(o_empty), 64'(2'b10));

      // Synchronous clear overrides a push and a credit in the same cycle
      step(2'b11, 32'h9999, 1'b1, 2'b00);
      @(posedge noc_clk);
      #1;
      i_clear  = 1'b1;
      i_valid  = 2'b10;
      i_flit   = 32'h9000;
      i_credit = 2'b01;
      @(posedge noc_clk);
      #1;
      i_clear  = 1'b0;
      i_valid  = '0;
      i_credit = '0;
      @(negedge noc_clk);
      chk("clr_empty", 64'(o_empty), 64'(2'b11));
      chk("clr_error", 64'(o_error), 64'(0));
      step(2'b01, 32'h9100, 1'b1, 2'b00);
      step(2'b01, 32'h9101, 1'b1, 2'b00);
      step(2'b01, 32'h9102, 1'b1, 2'b00);
      step('0, '0, 1'b1, 2'b00);
      step('0, '0, 1'b1, 2'b00);
      @(negedge noc_clk) chk("clr_credit", 64'(o_valid), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/noc_vc_credit_buffer.md
NOC_VC_CREDIT_BUFFER -- requirements
Module: noc_vc_credit_buffer

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- CHANNELS, Noc_VC_Channel, virtual-channel count (>=2).
- DEPTH, 8, flits per VC queue (power of 2, >=2).
- FLIT_WIDTH, Noc_Flit_Width, flit bits.
- CREDITS, 4, downstream buffer slots per VC (>=1).
REQ-002 Ports SHALL be as follows (name, direction, width, meaning); noc_clk and noc_rst_n are listed first:
- noc_clk, in, 1, single clock; all logic on rising edge.
- noc_rst_n, in, 1, asynchronous active-low reset.
- i_clear, in, 1, synchronous clear.
- i_valid, in, CHANNELS, one-hot push, bit = target VC.
- i_flit, in, FLIT_WIDTH, push data.
- o_ready, out, CHANNELS, per-VC queue not full.
- o_credit_return, out, CHANNELS, one-cycle pulse per flit sent from VC i (to upstream).
- o_valid, out, 1, output flit valid.
- o_vc, out, CHANNELS, one-hot VC of output flit.
- o_flit, out, FLIT_WIDTH, output data.
- i_ready, in, 1, downstream accepts.
- i_credit, in, CHANNELS, downstream credit return, one per bit per cycle.
- o_empty, out, CHANNELS, per-VC empty.
- o_full, out, CHANNELS, per-VC full.
- o_error, out, 2, sticky: [0] non-one-hot i_valid, [1] credit overflow.

Function
REQ-003 Push SHALL occur for VC i when i_valid[i] && o_ready[i] and i_valid is one-hot; a push to a full VC SHALL be dropped with no state change.
REQ-004 i_valid with more than one bit set SHALL push nothing and set o_error[0].
REQ-005 Each VC SHALL be an independent FIFO; order is preserved within a VC and not across VCs.
REQ-006 A flit pushed in cycle t SHALL become eligible for output in cycle t+1 (no same-cycle fall-through).
REQ-007 Each VC SHALL hold a credit counter of width $clog2(CREDITS+1), initialised to CREDITS.
REQ-008 A VC SHALL be eligible when non-empty and credit > 0.
REQ-009 Among eligible VCs, a round-robin arbiter SHALL select one; the priority pointer SHALL move to (granted VC + 1) mod CHANNELS only on a transfer (o_valid && i_ready).
REQ-010 While o_valid && !i_ready, o_vc and o_flit SHALL hold stable and the grant SHALL stay locked.
REQ-011 On transfer, the VC SHALL pop, its credit SHALL decrement, and o_credit_return[vc] SHALL pulse in the next cycle (registered).
REQ-012 For i_credit[i]: credit SHALL increment; a simultaneous send on the same VC SHALL leave it unchanged.
REQ-013 An increment that would exceed CREDITS SHALL saturate at CREDITS and set o_error[1].
REQ-014 o_valid SHALL be 0 when no VC is eligible; o_vc SHALL be 0 when o_valid is 0.
REQ-015 Push and pop on the same VC in the same cycle SHALL both succeed, with occupancy unchanged.
REQ-016 Pushes to a VC with zero credit SHALL be accepted until that VC is full.
REQ-017 o_ready, o_empty and o_full SHALL be registered.

Reset
REQ-018 On noc_rst_n low, asynchronously:
- all queues empty; o_empty all 1; o_full 0; o_ready all 1.
- credits = CREDITS; RR pointer = 0.
- o_valid, o_vc, o_credit_return, o_error = 0.
REQ-019 i_clear SHALL produce the same state synchronously, overriding any push, pop or credit in that cycle.
REQ-020 Reset asserted mid-transfer SHALL discard the in-flight flit with no credit-return pulse.

Structure
REQ-021 CHANNELS and FLIT_WIDTH defaults SHALL come from package Noc_parameters; the new localparam CREDIT_W SHALL be added there.
REQ-022 Per-VC storage SHALL instantiate the existing Noc_fifo (FLAG_FF_OUT=1).
REQ-023 Arbitration SHALL be one new sub-module, noc_rr_arbiter (parametrised by request count, with a lock input).

Verification
REQ-024 CHANNELS=2, DEPTH=4, CREDITS=2 for all scenarios:
- Push A0,A1,A2 to VC0 with i_credit=0 and i_ready=1: out A0,A1 on consecutive cycles; A2 holds until i_credit[0] pulses, then out one cycle later.
- Push 4 flits to VC1, then a 5th: o_full[1]=1, o_ready[1]=0, 5th dropped, output order intact.
- Both VCs loaded, credits ample, i_ready=1: o_vc alternates 01,10,01,10.
- i_ready=0 for 3 cycles with o_valid=1: o_flit and o_vc stable; one transfer when released; o_credit_return pulse one cycle after.
- i_credit[0] pulse with VC0 credit=2: counter stays 2 and o_error[1]=1; i_valid=2'b11: no push and o_error[0]=1.
- Reset asserted with 3 flits queued: all o_empty=1, credits=2, o_valid=0 immediately (asynchronous).
